conv_accumulator_27: RTL and testbench
======================================

# conv_accumulator_27

Pipelined reduction stage directly downstream of the 27-lane fixed-point multiplier array. It sums the 27 signed products of one 3×3×3 kernel window with a registered adder tree. It accumulates that partial sum across `NUM_GROUPS` consecutive input-channel groups, then adds a bias, saturates, optionally applies ReLU, and emits one output pixel with a one-cycle valid strobe. Throughput is one product vector per clock.

## Interface
- `bitsize`, 14: width of each product, bias and result (signed, same Q format).
- `FRAC_BITS`, 7: fraction bits of that format. Informational only; no rescaling is performed.
- `NUM_GROUPS`, 1: product vectors accumulated per output. Legal range is 1..64.
- `clk` input 1: single clock, all logic on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `mul_result` input bitsize*27: packed signed products; lane i is at bits [i*bitsize +: bitsize].
- `mul_valid` input 1: the product vector is valid this cycle (the multiplier array's AND-reduced valid).
- `bias` input bitsize: signed bias. It is quasi-static and must be held stable from the first `mul_valid` of an output until its `out_valid`.
- `relu_en` input 1: clamp negative results to 0. Sampled at the final edge.
- `clear` input 1: synchronous flush of the pipeline and accumulator.
- `acc_result` output bitsize: signed, saturated output pixel.
- `out_valid` output 1: single-cycle strobe; `acc_result` is valid while it is high.

## Operation
- Internal width: `ACC_W = bitsize + 5 + clog2(NUM_GROUPS)`. All internal sums are sign-extended to `ACC_W` and computed exactly, with no rounding.
- Stage 1 (27→9): nine registered 3-input sums of adjacent lanes; `v1 <= mul_valid`.
- Stage 2 (9→3): three registered 3-input sums; `v2 <= v1`.
- Stage 3 (3→1): one registered tree sum `s3`; `v3 <= v2`.
- Stage 4 (accumulate/finalize), on each edge where `v3 = 1`:
  - If `grp_cnt < NUM_GROUPS-1`: `acc <= acc + s3` and `grp_cnt++`. `out_valid <= 0`.
  - If `grp_cnt == NUM_GROUPS-1`:
    - `t = acc + s3 + bias`.
    - `acc_result <= sat(t)`, clamped to [-2^(bitsize-1), 2^(bitsize-1)-1].
    - If `relu_en` and `sat(t) < 0`, `acc_result <= 0` instead.
    - `out_valid <= 1`, `acc <= 0`, `grp_cnt <= 0`.
- On each edge where `v3 = 0`: `out_valid <= 0`; `acc`, `grp_cnt` and `acc_result` hold.
- `clear = 1` zeroes `v1`, `v2`, `v3`, `acc`, `grp_cnt` and `out_valid`. `acc_result` holds. Clear has priority over a simultaneous `v3` or `mul_valid`.
- Reset (`rst = 0`, asynchronous) zeroes every register, including all stage sums. Therefore `acc_result = 0` and `out_valid = 0` during and after reset.
  - A reset or clear mid-accumulation discards the partial groups. The next `mul_valid` is treated as group 0.
- With `NUM_GROUPS = 1`, every `v3` produces an output.

## Timing
- A `mul_valid` at cycle T yields `v3` at T+3. If that vector is the last group, `out_valid` is high at T+4.
- Latency from the last group's `mul_valid` to `out_valid` is 4 cycles, independent of `NUM_GROUPS`.
- Back-to-back `mul_valid` is fully supported with no stall and no backpressure. Outputs occur once every `NUM_GROUPS` valid inputs.
- Gaps in `mul_valid` are allowed and only delay the groups.
- `out_valid` is never high for two consecutive cycles unless `NUM_GROUPS = 1` and the inputs are consecutive.

## Structure
- Shared package holds:
  - defaults for `bitsize` and `FRAC_BITS`;
  - `NUM_PRODUCTS = 27`;
  - the `ACC_W` computation;
  - the saturation min/max constant functions.
- One sub-module, `add3_reg`: a signed 3-input adder with a registered output and async active-low reset. It is instantiated 13 times (9 + 3 + 1) across stages 1–3.
- The stage-4 accumulator, counter and saturation/ReLU logic live in the top module.

## Test plan
- **Single group sum:** `NUM_GROUPS=1`, all lanes 128 (1.0), bias 0, one `mul_valid` at T → `out_valid` at T+4 only, `acc_result = 3456`.
- **Saturation:** `NUM_GROUPS=1`.
  - All lanes 8191 → 8191.
  - All lanes -8192 → -8192.
  - 13 lanes at 100, 14 lanes at -100, bias 50 → -50.
- **Multi-group with bias:** `NUM_GROUPS=3`, three vectors each with all lanes 64, bias 128 → exactly one `out_valid`, 4 cycles after the third input, `acc_result = 5312`.
- **Throughput:** `NUM_GROUPS=2`, 8 consecutive vectors where vector k has all lanes = k → 4 strobes, 2 cycles apart, with values 27, 135, 243, 351.
- **ReLU:** all lanes -128, bias 0.
  - `relu_en=1` → 0.
  - `relu_en=0` → -3456.
- **Flush/reset:** `NUM_GROUPS=3`, two groups sent, then `clear` pulsed, then 3 groups with all lanes 1 → output 81 with no contribution from the flushed groups. Repeat with an async `rst` low mid-stage-2 → all outputs 0 and no spurious `out_valid`.

Source files
------------

// File: rtl/conv_accumulator_27_pkg.sv
// Shared constants and helpers for the 27-lane convolution accumulator.
// Holds format defaults, tree geometry, accumulator width and saturation bounds.
package conv_accumulator_27_pkg;

    localparam int BITSIZE_DEFAULT   = 14;
    localparam int FRAC_BITS_DEFAULT = 7;
    localparam int NUM_PRODUCTS      = 27;
    localparam int NUM_STAGE1        = NUM_PRODUCTS / 3;
    localparam int NUM_STAGE2        = NUM_STAGE1 / 3;
    localparam int MAX_GROUPS        = 64;

    // 27 products need 5 growth bits; each doubling of the group count adds one more.
    function automatic int acc_width(input int bitsize, input int num_groups);
        return bitsize + 5 + $clog2(num_groups);
    endfunction

    function automatic longint sat_max(input int width);
        return (longint'(1) <<< (width - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage

// File: rtl/conv_accumulator_27_add3_reg.sv
// Signed 3-input adder with a registered, sign-extended output.
// Building block of the 27 -> 9 -> 3 -> 1 reduction tree.
module add3_reg #(
    parameter int IN_W  = 14,
    parameter int OUT_W = 19
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [IN_W-1:0]  a,
    input  logic signed [IN_W-1:0]  b,
    input  logic signed [IN_W-1:0]  c,
    output logic signed [OUT_W-1:0] sum
);

    // NOTE: a size cast of a signed operand sign-extends, so the sum is exact in OUT_W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum <= '0;
        end else begin
            sum <= OUT_W'(a) + OUT_W'(b) + OUT_W'(c);
        end
    end

endmodule

// File: rtl/conv_accumulator_27.sv
// Reduces one 27-lane product vector per clock, accumulates NUM_GROUPS vectors,
// then adds bias, saturates, optionally applies ReLU and strobes one output pixel.
module conv_accumulator_27
    import conv_accumulator_27_pkg::*;
#(
    parameter int bitsize    = BITSIZE_DEFAULT,
    parameter int FRAC_BITS  = FRAC_BITS_DEFAULT,
    parameter int NUM_GROUPS = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [bitsize*NUM_PRODUCTS-1:0]   mul_result,
    input  logic                              mul_valid,
    input  logic signed [bitsize-1:0]         bias,
    input  logic                              relu_en,
    input  logic                              clear,
    output logic signed [bitsize-1:0]         acc_result,
    output logic                              out_valid
);

    localparam int ACC_W = acc_width(bitsize, NUM_GROUPS);
    localparam int CNT_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

    localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(NUM_GROUPS - 1);

    localparam longint SAT_MAX_L = sat_max(bitsize);
    localparam longint SAT_MIN_L = sat_min(bitsize);

    localparam logic signed [ACC_W-1:0]   SAT_MAX = ACC_W'(SAT_MAX_L);
    localparam logic signed [ACC_W-1:0]   SAT_MIN = ACC_W'(SAT_MIN_L);
    localparam logic signed [bitsize-1:0] RES_MAX = bitsize'(SAT_MAX_L);
    localparam logic signed [bitsize-1:0] RES_MIN = bitsize'(SAT_MIN_L);

    // FRAC_BITS only documents the shared Q format; it must fit inside the word.
    if (NUM_GROUPS < 1 || NUM_GROUPS > MAX_GROUPS ||
        FRAC_BITS < 0 || FRAC_BITS >= bitsize) begin : g_param_check
        $error("conv_accumulator_27: illegal NUM_GROUPS or FRAC_BITS");
    end

    logic signed [bitsize-1:0] lane [NUM_PRODUCTS];
    logic signed [ACC_W-1:0]   s1   [NUM_STAGE1];
    logic signed [ACC_W-1:0]   s2   [NUM_STAGE2];
    logic signed [ACC_W-1:0]   s3;

    logic v1;
    logic v2;
    logic v3;

    logic signed [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]          grp_cnt;
    logic signed [ACC_W-1:0]   t_sum;
    logic signed [bitsize-1:0] sat_val;
    logic signed [bitsize-1:0] final_val;

    for (genvar i = 0; i < NUM_PRODUCTS; i++) begin : g_lane
        assign lane[i] = mul_result[i*bitsize +: bitsize];
    end

    for (genvar j = 0; j < NUM_STAGE1; j++) begin : g_stage1
        add3_reg #(
            .IN_W  (bitsize),
            .OUT_W (ACC_W)
        ) u_add (
            .clk (clk),
            .rst (rst),
            .a   (lane[3*j]),
            .b   (lane[3*j+1]),
            .c   (lane[3*j+2]),
            .sum (s1[j])
        );
    end

    for (genvar j = 0; j < NUM_STAGE2; j++) begin : g_stage2
        add3_reg #(
            .IN_W  (ACC_W),
            .OUT_W (ACC_W)
        ) u_add (
            .clk (clk),
            .rst (rst),
            .a   (s1[3*j]),
            .b   (s1[3*j+1]),
            .c   (s1[3*j+2]),
            .sum (s2[j])
        );
    end

    add3_reg #(
        .IN_W  (ACC_W),
        .OUT_W (ACC_W)
    ) u_stage3 (
        .clk (clk),
        .rst (rst),
        .a   (s2[0]),
        .b   (s2[1]),
        .c   (s2[2]),
        .sum (s3)
    );

    // The stage sums are free-running; only the valid shift register marks live data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else if (clear) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            v1 <= mul_valid;
            v2 <= v1;
            v3 <= v2;
        end
    end

    always_comb begin
        t_sum = acc + s3 + ACC_W'(bias);
        if (t_sum > SAT_MAX) begin
            sat_val = RES_MAX;
        end else if (t_sum < SAT_MIN) begin
            sat_val = RES_MIN;
        end else begin
            sat_val = t_sum[bitsize-1:0];
        end
        final_val = (relu_en && sat_val[bitsize-1]) ? '0 : sat_val;
    end

    // acc_result deliberately survives a clear so the last pixel stays readable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc        <= '0;
            grp_cnt    <= '0;
            acc_result <= '0;
            out_valid  <= 1'b0;
        end else if (clear) begin
            acc        <= '0;
            grp_cnt    <= '0;
            out_valid  <= 1'b0;
        end else if (v3) begin
            if (grp_cnt == LAST_GRP) begin
                acc_result <= final_val;
                out_valid  <= 1'b1;
                acc        <= '0;
                grp_cnt    <= '0;
            end else begin
                acc        <= acc + s3;
                grp_cnt    <= grp_cnt + 1'b1;
                out_valid  <= 1'b0;
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_accumulator_27.sv
// Scoreboard bench: three instances (NUM_GROUPS = 1, 2, 3) share data inputs but
// have private valids; a reference model queues expected pixels and their cycle.
module tb_conv_accumulator_27;

    localparam int BW = 14;
    localparam int NP = 27;
    localparam int NG [3] = '{1, 2, 3};
    localparam int RMAX = (1 << (BW - 1)) - 1;
    localparam int RMIN = -(1 << (BW - 1));

    typedef struct {
        int value;
        int cycle;
    } exp_t;

    logic                   clk;
    logic                   rst;
    logic [BW*NP-1:0]       mul_result;
    logic                   mv  [3];
    logic signed [BW-1:0]   bias;
    logic                   relu_en;
    logic                   clear;
    logic signed [BW-1:0]   res [3];
    logic                   ov  [3];

    exp_t q [3][$];
    int   m_acc [3];
    int   m_cnt [3];
    int   cyc;
    int   total;
    int   bad;

    conv_accumulator_27 #(.bitsize(BW), .FRAC_BITS(7), .NUM_GROUPS(1)) u_dut_g1 (
        .clk(clk), .rst(rst), .mul_result(mul_result), .mul_valid(mv[0]), .bias(bias),
        .relu_en(relu_en), .clear(clear), .acc_result(res[0]), .out_valid(ov[0])
    );
    conv_accumulator_27 #(.bitsize(BW), .FRAC_BITS(7), .NUM_GROUPS(2)) u_dut_g2 (
        .clk(clk), .rst(rst), .mul_result(mul_result), .mul_valid(mv[1]), .bias(bias),
        .relu_en(relu_en), .clear(clear), .acc_result(res[1]), .out_valid(ov[1])
    );
    conv_accumulator_27 #(.bitsize(BW), .FRAC_BITS(7), .NUM_GROUPS(3)) u_dut_g3 (
        .clk(clk), .rst(rst), .mul_result(mul_result), .mul_valid(mv[2]), .bias(bias),
        .relu_en(relu_en), .clear(clear), .acc_result(res[2]), .out_valid(ov[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every strobe must match the head of its instance's queue, value and cycle.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (ov[k] === 1'b1) begin
                total++;
                if (q[k].size() == 0) begin
                    bad++;
                    $display("FAIL spurious_strobe_g%0d: got value=%0d at cyc %0d, expected no strobe",
                             NG[k], res[k], cyc);
                end else begin
                    e = q[k].pop_front();
                    if (res[k] !== e.value[BW-1:0] || cyc != e.cycle) begin
                        bad++;
                        $display("FAIL out_g%0d: got %0d at cyc %0d, expected %0d at cyc %0d",
                                 NG[k], res[k], cyc, e.value, e.cycle);
                    end
                end
            end
        end
    end

    function automatic logic [BW*NP-1:0] uniform(input int v);
        logic [BW*NP-1:0] vec;
        for (int i = 0; i < NP; i++) vec[i*BW +: BW] = v[BW-1:0];
        return vec;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one vector to instance k for one cycle and advances the model.
    task automatic send(input int k, input logic [BW*NP-1:0] vec);
        int s;
        int t;
        logic signed [BW-1:0] ln;
        exp_t e;
        s = 0;
        for (int i = 0; i < NP; i++) begin
            ln = vec[i*BW +: BW];
            s += int'(ln);
        end
        if (m_cnt[k] == NG[k] - 1) begin
            t = m_acc[k] + s + int'(bias);
            if (t > RMAX) t = RMAX;
            else if (t < RMIN) t = RMIN;
            if (relu_en && t < 0) t = 0;
            e.value = t;
            e.cycle = cyc + 4;
            q[k].push_back(e);
            m_acc[k] = 0;
            m_cnt[k] = 0;
        end else begin
            m_acc[k] += s;
            m_cnt[k]++;
        end
        mul_result = vec;
        mv[k] = 1'b1;
        tick();
        mv[k] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < 60) begin
            tick();
            n++;
        end
        total++;
        if (n >= 60) begin
            bad++;
            $display("FAIL drain_timeout: pending=%0d, expected 0",
                     q[0].size() + q[1].size() + q[2].size());
            for (int k = 0; k < 3; k++) q[k].delete();
        end
        repeat (4) tick();
    endtask

    task automatic reset_model();
        for (int k = 0; k < 3; k++) begin
            q[k].delete();
            m_acc[k] = 0;
            m_cnt[k] = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) tick();
        for (int k = 0; k < 3; k++) begin
            total++;
            if (ov[k] !== 1'b0 || res[k] !== '0) begin
                bad++;
                $display("FAIL reset_state_g%0d: got ov=%b res=%0d, expected ov=0 res=0",
                         NG[k], ov[k], res[k]);
            end
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_group();
        bias = '0;
        send(0, uniform(128));
        drain();
    endtask

    task automatic test_saturation();
        logic [BW*NP-1:0] vec;
        int v;
        send(0, uniform(8191));
        tick();
        send(0, uniform(-8192));
        drain();
        for (int i = 0; i < NP; i++) begin
            v = (i < 13) ? 100 : -100;
            vec[i*BW +: BW] = v[BW-1:0];
        end
        bias = 14'sd50;
        send(0, vec);
        drain();
        bias = '0;
    endtask

    task automatic test_multi_group_bias();
        bias = 14'sd128;
        send(2, uniform(64));
        send(2, uniform(64));
        repeat (3) tick();
        send(2, uniform(64));
        drain();
        bias = '0;
    endtask

    task automatic test_back_to_back();
        for (int v = 0; v < 8; v++) send(1, uniform(v));
        drain();
        send(0, uniform(10));
        send(0, uniform(-20));
        send(0, uniform(30));
        send(0, uniform(-40));
        drain();
    endtask

    task automatic test_relu();
        relu_en = 1'b1;
        send(0, uniform(-128));
        send(0, uniform(5));
        drain();
        relu_en = 1'b0;
        send(0, uniform(-128));
        drain();
    endtask

    task automatic test_clear();
        send(2, uniform(500));
        send(2, uniform(500));
        repeat (4) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        m_acc[2] = 0;
        m_cnt[2] = 0;
        for (int g = 0; g < 3; g++) send(2, uniform(1));
        drain();
        // A clear coinciding with v3 must swallow that vector's output.
        send(0, uniform(9));
        repeat (2) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        void'(q[0].pop_back());
        drain();
    endtask

    task automatic test_async_reset();
        send(2, uniform(7));
        send(2, uniform(7));
        send(0, uniform(3));
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        reset_model();
        for (int k = 0; k < 3; k++) begin
            total++;
            if (ov[k] !== 1'b0 || res[k] !== '0) begin
                bad++;
                $display("FAIL async_reset_g%0d: got ov=%b res=%0d, expected ov=0 res=0",
                         NG[k], ov[k], res[k]);
            end
        end
        repeat (2) tick();
        rst = 1'b1;
        for (int n = 0; n < 6; n++) begin
            tick();
            total++;
            if (ov[0] !== 1'b0 || ov[1] !== 1'b0 || ov[2] !== 1'b0) begin
                bad++;
                $display("FAIL post_reset_quiet: got ov=%b%b%b, expected 000",
                         ov[2], ov[1], ov[0]);
            end
        end
        for (int g = 0; g < 3; g++) send(2, uniform(1));
        drain();
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        cyc        = 0;
        rst        = 1'b0;
        mul_result = '0;
        mv         = '{1'b0, 1'b0, 1'b0};
        bias       = '0;
        relu_en    = 1'b0;
        clear      = 1'b0;
        reset_model();
        tick();

        test_reset();
        test_single_group();
        test_saturation();
        test_multi_group_bias();
        test_back_to_back();
        test_relu();
        test_clear();
        test_async_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
